// File: rtl/score_display_pkg.sv
// Shared constants for the score renderer: glyph ROM, digit geometry, FSM states.
package score_display_pkg;

  localparam int GLYPH_COLS  = 4;
  localparam int GLYPH_ROWS  = 9;
  localparam int DIGIT_PITCH = 5;
  localparam int NUM_GLYPHS  = 11;

  localparam logic [3:0] ERR_GLYPH = 4'd10;

  // Column 0 is leftmost; bit r of a column word is row r, row 0 at the top.
  typedef logic [0:GLYPH_COLS-1][GLYPH_ROWS-1:0] glyph_t;

  localparam glyph_t GLYPH_ROM [NUM_GLYPHS] = '{
    '{9'h1FF, 9'h101, 9'h101, 9'h1FF},
    '{9'h000, 9'h000, 9'h000, 9'h1FF},
    '{9'h1F1, 9'h111, 9'h111, 9'h11F},
    '{9'h111, 9'h111, 9'h111, 9'h1FF},
    '{9'h01F, 9'h010, 9'h010, 9'h1FF},
    '{9'h11F, 9'h111, 9'h111, 9'h1F1},
    '{9'h1FF, 9'h110, 9'h110, 9'h1F0},
    '{9'h001, 9'h001, 9'h001, 9'h1FF},
    '{9'h1FF, 9'h111, 9'h111, 9'h1FF},
    '{9'h01F, 9'h011, 9'h011, 9'h1FF},
    '{9'h003, 9'h001, 9'h171, 9'h01F}
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_COMMIT
  } conv_state_e;

  function automatic int unsigned max_val(input int unsigned num_digits);
    int unsigned r = 1;
    for (int i = 0; i < int'(num_digits); i++) r = r * 10;
    return r - 1;
  endfunction

endpackage

// File: rtl/score_display_if.sv
// Score update handshake between the game logic and the score renderer.
interface score_display_if #(
  parameter int VALUE_W = 10
);
  logic [VALUE_W-1:0] Value;
  logic               ValueValid;
  logic               Ready;
  logic               BlankLZ;
  logic               Done;
  logic               Overflow;

  modport master (output Value, ValueValid, BlankLZ, input Ready, Done, Overflow);
  modport slave  (input Value, ValueValid, BlankLZ, output Ready, Done, Overflow);
endinterface

// File: rtl/score_display_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter with valid/ready intake
// and a one-cycle commit strobe once the BCD result is final.
module bcd_converter
  import score_display_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int VALUE_W    = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [VALUE_W-1:0]      value,
  input  logic                    value_valid,
  output logic                    ready,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    ovf,
  output logic                    commit
);
  localparam int CNT_W = $clog2(VALUE_W + 1);

  conv_state_e             state;
  logic [VALUE_W-1:0]      bin;
  logic [CNT_W-1:0]        cnt;
  logic [4*NUM_DIGITS-1:0] adj;

  // NOTE: give every always_comb output a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    adj = bcd;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (bcd[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_IDLE;
      ready  <= 1'b1;
      commit <= 1'b0;
      bcd    <= '0;
      bin    <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      commit <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (value_valid) begin
            bin   <= value;
            ovf   <= 32'(value) > max_val(NUM_DIGITS);
            bcd   <= '0;
            cnt   <= '0;
            ready <= 1'b0;
            state <= S_CONV;
          end
        end
        S_CONV: begin
          // The top bit of the adjusted BCD falls off: digits beyond NUM_DIGITS are dropped.
          {bcd, bin} <= {adj[4*NUM_DIGITS-2:0], bin, 1'b0};
          cnt        <= cnt + 1'b1;
          if (cnt == CNT_W'(VALUE_W - 1)) begin
            state  <= S_COMMIT;
            commit <= 1'b1;
          end
        end
        S_COMMIT: begin
          state <= S_IDLE;
          ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/score_display.sv
// Decimal score renderer: holds committed digits and blanking, and answers
// per-pixel polls through a two-stage pipeline with a registered Hit.
module score_display
  import score_display_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int VALUE_W    = 10,
  parameter int X_W        = 11,
  parameter int Y_W        = 10,
  parameter int PX_W       = 10,
  parameter int PY_W       = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [X_W-1:0]  ObjectX,
  input  logic [Y_W-1:0]  ObjectY,
  input  logic [3:0]      ObjectScale,
  input  logic [PX_W-1:0] PollX,
  input  logic [PY_W-1:0] PollY,
  output logic            Hit,
  score_display_if.slave  sif
);
  localparam int             CX_W   = $clog2(NUM_DIGITS * DIGIT_PITCH);
  localparam int             CY_W   = $clog2(GLYPH_ROWS);
  localparam logic [X_W:0]   CX_LIM = (X_W+1)'(NUM_DIGITS * DIGIT_PITCH);
  localparam logic [Y_W:0]   CY_LIM = (Y_W+1)'(GLYPH_ROWS);

  logic [4*NUM_DIGITS-1:0] conv_bcd;
  logic                    conv_ovf;
  logic                    commit;

  bcd_converter #(.NUM_DIGITS(NUM_DIGITS), .VALUE_W(VALUE_W)) u_conv (
    .clk         (clk),
    .reset       (reset),
    .value       (sif.Value),
    .value_valid (sif.ValueValid),
    .ready       (sif.Ready),
    .bcd         (conv_bcd),
    .ovf         (conv_ovf),
    .commit      (commit)
  );

  assign sif.Done = commit;

  // Display registers; index 0 is the most significant digit.
  logic [3:0]            digit_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] blank_q, blank_next;
  logic                  overflow_q, all_zero;

  always_comb begin
    blank_next = '0;
    all_zero   = sif.BlankLZ;
    for (int d = 0; d < NUM_DIGITS - 1; d++) begin
      all_zero      = all_zero && (conv_bcd[4*(NUM_DIGITS-1-d) +: 4] == 4'd0);
      blank_next[d] = all_zero;
    end
  end

  // NOTE: the digit array is reset explicitly because "000" must be shown out
  // of reset; arrays that need no defined start value are better left unreset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int d = 0; d < NUM_DIGITS; d++) digit_q[d] <= '0;
      blank_q    <= '0;
      overflow_q <= 1'b0;
    end else if (commit) begin
      for (int d = 0; d < NUM_DIGITS; d++) digit_q[d] <= conv_bcd[4*(NUM_DIGITS-1-d) +: 4];
      blank_q    <= conv_ovf ? '0 : blank_next;
      overflow_q <= conv_ovf;
    end
  end

  assign sif.Overflow = overflow_q;

  // Stage 1: cell coordinates; a negative offset becomes huge when viewed unsigned.
  logic signed [X_W:0] dx, cx;
  logic signed [Y_W:0] dy, cy;
  logic [CX_W-1:0]     cx_q;
  logic [CY_W-1:0]     cy_q;
  logic                in_range_q;

  always_comb begin
    dx = $signed({{(X_W+1-PX_W){1'b0}}, PollX}) - $signed({1'b0, ObjectX});
    dy = $signed({{(Y_W+1-PY_W){1'b0}}, PollY}) - $signed({1'b0, ObjectY});
    cx = dx >>> ObjectScale;
    cy = dy >>> ObjectScale;
  end

  // Stage 2: digit/column decode and glyph lookup against the live display regs.
  logic [CX_W-1:0] d_sel, col;
  logic [3:0]      glyph_idx;
  logic            blanked, lit;

  always_comb begin
    d_sel     = cx_q / CX_W'(DIGIT_PITCH);
    col       = cx_q % CX_W'(DIGIT_PITCH);
    glyph_idx = ERR_GLYPH;
    blanked   = 1'b1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (d_sel == CX_W'(d)) begin
        glyph_idx = overflow_q ? ERR_GLYPH : digit_q[d];
        blanked   = blank_q[d];
      end
    end
    lit = 1'b0;
    if (in_range_q && col != CX_W'(GLYPH_COLS))
      lit = !blanked && GLYPH_ROM[glyph_idx][col[1:0]][cy_q];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      in_range_q <= 1'b0;
      cx_q       <= '0;
      cy_q       <= '0;
      Hit        <= 1'b0;
    end else begin
      in_range_q <= ($unsigned(cx) < CX_LIM) && ($unsigned(cy) < CY_LIM);
      cx_q       <= cx[CX_W-1:0];
      cy_q       <= cy[CY_W-1:0];
      Hit        <= lit;
    end
  end

endmodule

// File: doc/score_display.md
Name: score_display

Overview:
- Parametrised multi-digit decimal score renderer for the pong VGA path.
- Accepts a binary score via a valid/ready handshake and converts it to BCD with a sequential double-dabble FSM. Digits are committed atomically to display registers.
- Answers per-pixel poll queries with a registered Hit flag, which is ORed into the pixel colour mux alongside the paddle/ball objects.
- Adds leading-zero blanking and overflow indication.

Parameters:
- NUM_DIGITS, 3, number of displayed decimal digits (1..5).
- VALUE_W, 10, width of binary Value input.
- X_W, 11, ObjectX width.
- Y_W, 10, ObjectY width.
- PX_W, 10, PollX width.
- PY_W, 9, PollY width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- ObjectX  in  X_W  top-left X of the leftmost digit.
- ObjectY  in  Y_W  top-left Y.
- ObjectScale  in  4  cell size = 2^ObjectScale pixels.
- Value  in  VALUE_W  binary score.
- ValueValid  in  1  Value offered.
- Ready  out  1  block idle, can accept Value.
- BlankLZ  in  1  blank leading zeros; sampled at commit.
- Done  out  1  one-cycle pulse when the new digits are committed.
- Overflow  out  1  last committed Value exceeded 10^NUM_DIGITS-1.
- PollX  in  PX_W  pixel X to test.
- PollY  in  PY_W  pixel Y to test.
- Hit  out  1  polled pixel lies on a lit cell.

Behaviour:
- Reset (reset==0 at a clk edge):
  - FSM to IDLE.
  - All digits = 0, blank mask = 0 (so "000" is displayed).
  - Overflow=0, Done=0, Hit=0, pipeline valids=0.
  - Reset mid-conversion aborts the conversion; nothing is committed.
- Glyphs: 4 columns x 9 rows per digit. Column 0 is leftmost; in each column word, bit r = row r, with row 0 at the top. Columns 0..3 in hex:
  - 0: 1FF,101,101,1FF
  - 1: 000,000,000,1FF
  - 2: 1F1,111,111,11F
  - 3: 111,111,111,1FF
  - 4: 01F,010,010,1FF
  - 5: 11F,111,111,1F1
  - 6: 1FF,110,110,1F0
  - 7: 001,001,001,1FF
  - 8: 1FF,111,111,1FF
  - 9: 01F,011,011,1FF
  - ERR: 003,001,171,01F
- FSM IDLE / CONV / COMMIT:
  - IDLE: Ready=1. On ValueValid&&Ready, capture Value and compute ovf = (Value > MAX_VAL), clear BCD, counter=0, go to CONV.
  - CONV: Ready=0. Each cycle, add 3 to every BCD nibble >= 5, then shift {bcd,bin} left by 1. Nibbles beyond NUM_DIGITS are discarded. After VALUE_W cycles, go to COMMIT.
  - COMMIT: write digit regs, Overflow<=ovf, blank mask, Done=1 for this cycle only; go to IDLE.
  - Timing: Value is accepted in cycle t, Done is high in cycle t+VALUE_W+1, and Ready returns in cycle t+VALUE_W+2.
  - ValueValid while Ready=0 is ignored; no queuing.
- Overflow: when Overflow=1, every digit renders ERR and the blank mask is forced to 0.
- Blank mask: with BlankLZ=1, digit i is blanked when it and all more-significant digits are 0. The least-significant digit is never blanked.
- Poll pipeline, 2-cycle latency (Hit in cycle t+2 reflects PollX/PollY from cycle t):
  - Stage 1:
    - dx = zero-extended PollX - ObjectX and dy = PollY - ObjectY, both signed with X_W+1 / Y_W+1 bits; a negative result is a miss.
    - cx = dx>>>ObjectScale, cy = dy>>>ObjectScale.
    - Register cx, cy and in_range = (cx < NUM_DIGITS*5 && cy < 9).
  - Stage 2:
    - digit d = cx/5 (d=0 is the most significant digit), col = cx%5.
    - col==4 is the inter-digit gap and is a miss.
    - Otherwise Hit <= in_range && !blank[d] && glyph(digit[d])[col][cy].
  - Stage 2 reads the display registers current at that cycle; a commit is visible from the next sampled poll.
  - Scale shifts >= operand width give cx=0 / cy=0, which is legal.

Decomposition:
- Package score_display_pkg contains:
  - glyph ROM constant, 11 entries x 4 x 9 bits;
  - GLYPH_COLS=4, GLYPH_ROWS=9, DIGIT_PITCH=5;
  - ERR glyph index 10;
  - FSM state typedef;
  - function max_val(NUM_DIGITS).
- One sub-module, bcd_converter: holds the double-dabble FSM, handshake and ovf flag. It outputs the BCD vector plus a commit strobe. score_display keeps the display regs, blanking and poll pipeline.

Test Plan:
- Reset and poll: hold reset low 2 cycles; ObjectX=100, ObjectY=50, scale 0; Poll (100,50) -> Hit=1 two cycles later; Ready=1, Overflow=0, Done=0.
- Value=42, one-cycle ValueValid -> Done pulses exactly 11 cycles after acceptance. Poll (105,50) -> Hit=1 ("4" col0 row0); poll (105,58) -> Hit=0.
- Gap and scale: after reset, poll (104,50) -> Hit=0. With scale=2, poll (116,50) -> Hit=0 (gap); poll (120,50) -> Hit=1 (digit 1, col0).
- Overflow: Value=1000 -> Overflow=1 after Done; poll (103,52) -> Hit=1 (ERR col3 row2 = 01F). Then Value=5 -> Overflow=0.
- Blanking: BlankLZ=1, Value=7 -> polls on digits 0 and 1 (PollX 100..108, any row) give Hit=0; poll (113,50) -> Hit=1.
- Handshake: ValueValid with Value=99 during CONV is ignored and 42 is committed. Reset mid-CONV -> "000" displayed and Ready=1 on the first cycle after reset is released, with no Done pulse.
